// File: rtl/riscv_i32_interrupt_sequencer_pkg.sv
// riscv_i32_interrupt_pkg: shared state, mode and width definitions for the interrupt sequencer
package riscv_i32_interrupt_pkg;
   typedef enum logic [1:0] {IDLE, REQ, HANDLER} state_t;
   localparam logic [2:0] MODE_MACHINE = 3'd3;
   localparam int IRQ_NUM_W = 4;
endpackage

// File: rtl/riscv_i32_interrupt_sequencer_if.sv
// riscv_i32_interrupt_sequencer_if: interrupt lines, enables and pipeline handshake bundle
interface riscv_i32_interrupt_sequencer_if #(parameter int NUM_IRQ = 8);
   import riscv_i32_interrupt_pkg::*;
   logic [NUM_IRQ-1:0] irq_in;
   logic [NUM_IRQ-1:0] irq_enable;
   logic [NUM_IRQ-1:0] irq_pending;
   logic global_ie;
   logic interrupt_ack;
   logic trap_valid;
   logic trap_ret;
   logic interrupt_req;
   logic in_handler;
   logic [IRQ_NUM_W-1:0] interrupt_number;
   logic [2:0] interrupt_to_mode;
   modport master (
      output irq_in, irq_enable, global_ie, interrupt_ack, trap_valid, trap_ret,
      input irq_pending, interrupt_req, in_handler, interrupt_number, interrupt_to_mode
   );
   modport slave (
      input irq_in, irq_enable, global_ie, interrupt_ack, trap_valid, trap_ret,
      output irq_pending, interrupt_req, in_handler, interrupt_number, interrupt_to_mode
   );
endinterface

// File: rtl/riscv_i32_interrupt_sequencer_priority_encoder.sv
// riscv_i32_irq_priority_encoder: find-first-set (lowest index wins) with an any-flag
module riscv_i32_irq_priority_encoder #(parameter int N = 8) (
   input  logic [N-1:0] req,
   output logic [3:0]   index,
   output logic         any
);
   // scan from the top so the lowest set bit is the last one written
   always_comb begin
      index = '0;
      for (int i = N - 1; i >= 0; i--) index = req[i] ? 4'(i) : index;
   end
   assign any = |req;
endmodule

// File: rtl/riscv_i32_interrupt_sequencer.sv
// riscv_i32_interrupt_sequencer: synchronises, arbitrates and sequences interrupt entry/return
// Build option: RISCV_I32_INTERRUPT_SEQUENCER_EDGE_EN selects sticky rising-edge pending bits.
module riscv_i32_interrupt_sequencer
   import riscv_i32_interrupt_pkg::*;
#(
   parameter int         NUM_IRQ     = 8,
   parameter logic [2:0] TO_MODE     = MODE_MACHINE,
   parameter int         SYNC_STAGES = 2
) (
   input logic clk,
   input logic reset_n,
   riscv_i32_interrupt_sequencer_if.slave bus
);
   logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
   logic [NUM_IRQ-1:0] irq_sync, pending, cand, num_oh;
   logic [IRQ_NUM_W-1:0] win, num_q, num_d;
   logic any, hold;
   state_t state_q, state_d;

   // multi-flop synchroniser on the raw asynchronous lines
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) sync_q <= '0;
      else sync_q <= {sync_q[SYNC_STAGES-2:0], bus.irq_in};
   assign irq_sync = sync_q[SYNC_STAGES-1];

`ifdef RISCV_I32_INTERRUPT_SEQUENCER_EDGE_EN
   logic [NUM_IRQ-1:0] sync_d, pend_q, clr;
   // sticky pending: a fresh rising edge beats a same-cycle clear
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         sync_d <= '0;
         pend_q <= '0;
      end else begin
         sync_d <= irq_sync;
         pend_q <= (pend_q & ~clr) | (irq_sync & ~sync_d);
      end
   assign pending = pend_q;
   assign hold = |(num_oh & bus.irq_enable);
`else
   assign pending = irq_sync;
   assign hold = |(num_oh & cand);
`endif

   assign cand = pending & bus.irq_enable;
   assign num_oh = NUM_IRQ'(1) << num_q;

   riscv_i32_irq_priority_encoder #(.N(NUM_IRQ)) u_enc (
      .req(cand),
      .index(win),
      .any(any)
   );

   // state and latched cause number
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q <= IDLE;
         num_q <= '0;
      end else begin
         state_q <= state_d;
         num_q <= num_d;
      end

   // next state; the cause number only moves on the IDLE->REQ edge, ack beats withdraw
   always_comb begin
      state_d = state_q;
      num_d = num_q;
`ifdef RISCV_I32_INTERRUPT_SEQUENCER_EDGE_EN
      clr = '0;
`endif
      case (state_q)
         IDLE: begin
            state_d = (bus.global_ie && any) ? REQ : IDLE;
            num_d = (bus.global_ie && any) ? win : num_q;
         end
         REQ: begin
            state_d = bus.interrupt_ack ? HANDLER : (!bus.global_ie || !hold) ? IDLE : REQ;
`ifdef RISCV_I32_INTERRUPT_SEQUENCER_EDGE_EN
            clr = bus.interrupt_ack ? num_oh : '0;
`endif
         end
         HANDLER: state_d = bus.trap_ret ? IDLE : (bus.trap_valid ? HANDLER : state_q);
         default: state_d = IDLE;
      endcase
   end

   assign bus.interrupt_req = state_q == REQ;
   assign bus.in_handler = state_q == HANDLER;
   assign bus.interrupt_number = num_q;
   assign bus.interrupt_to_mode = TO_MODE;
   assign bus.irq_pending = pending;
endmodule

// File: tb/tb_riscv_i32_interrupt_sequencer.sv
// tb_riscv_i32_interrupt_sequencer: directed scoreboard bench for the interrupt sequencer
module tb_riscv_i32_interrupt_sequencer;
   localparam int S_REQ = 0, S_NUM = 1, S_INH = 2, S_PEND = 3, S_MODE = 4, S_BOTH = 5;
   typedef struct {
      string tag;
      int sel;
      logic [15:0] val;
   } item_t;

   logic clk = 1'b0;
   logic reset_n;
   int checks = 0;
   int errors = 0;
   item_t sb[$];

   riscv_i32_interrupt_sequencer_if #(.NUM_IRQ(8)) bus ();

   riscv_i32_interrupt_sequencer #(.NUM_IRQ(8), .TO_MODE(3'd3), .SYNC_STAGES(2)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] observe(int sel);
      case (sel)
         S_REQ:  return 16'(bus.interrupt_req);
         S_NUM:  return 16'(bus.interrupt_number);
         S_INH:  return 16'(bus.in_handler);
         S_PEND: return 16'(bus.irq_pending);
         S_MODE: return 16'(bus.interrupt_to_mode);
         default: return 16'(bus.interrupt_req & bus.in_handler);
      endcase
   endfunction

   task automatic want(string tag, int sel, logic [15:0] val);
      item_t it;
      it.tag = tag;
      it.sel = sel;
      it.val = val;
      sb.push_back(it);
   endtask

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_all();
      item_t it;
      logic [15:0] obs;
      want("req_and_handler_exclusive", S_BOTH, 16'd0);
      while (sb.size() > 0) begin
         it = sb.pop_front();
         obs = observe(it.sel);
         checks++;
         assert (obs === it.val) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", it.tag, obs, it.val);
         end
      end
   endtask

   initial begin
      reset_n = 1'b0;
      bus.irq_enable = 8'hFF;
      bus.global_ie = 1'b1;
      bus.interrupt_ack = 1'b0;
      bus.trap_valid = 1'b0;
      bus.trap_ret = 1'b0;
`ifdef RISCV_I32_INTERRUPT_SEQUENCER_EDGE_EN
      bus.irq_in = 8'h00;
      bus.global_ie = 1'b0;
`else
      bus.irq_in = 8'hFF;
`endif
      tick(3);
      want("reset_req", S_REQ, 0);
      want("reset_pending", S_PEND, 0);
      want("reset_handler", S_INH, 0);
      want("reset_num", S_NUM, 0);
      want("reset_mode", S_MODE, 3);
      check_all();
      reset_n = 1'b1;
`ifdef RISCV_I32_INTERRUPT_SEQUENCER_EDGE_EN
      bus.irq_in = 8'h04;
      tick(1);
      bus.irq_in = 8'h00;
      tick(4);
      want("edge_pending_sticky", S_PEND, 16'h04);
      want("edge_no_req_gie_off", S_REQ, 0);
      check_all();
      bus.global_ie = 1'b1;
      tick(1);
      want("edge_req", S_REQ, 1);
      want("edge_num", S_NUM, 2);
      check_all();
      tick(3);
      want("edge_pending_held", S_PEND, 16'h04);
      want("edge_req_held", S_REQ, 1);
      check_all();
      bus.interrupt_ack = 1'b1;
      tick(1);
      bus.interrupt_ack = 1'b0;
      want("edge_pending_cleared", S_PEND, 16'h00);
      want("edge_handler", S_INH, 1);
      check_all();
      bus.trap_ret = 1'b1;
      tick(1);
      bus.trap_ret = 1'b0;
      bus.irq_in = 8'h04;
      tick(1);
      bus.irq_in = 8'h00;
      tick(4);
      want("edge_req2", S_REQ, 1);
      want("edge_num2", S_NUM, 2);
      check_all();
      bus.irq_in = 8'h04;
      tick(1);
      bus.irq_in = 8'h00;
      tick(1);
      bus.interrupt_ack = 1'b1;
      tick(1);
      bus.interrupt_ack = 1'b0;
      want("edge_set_beats_clear", S_PEND, 16'h04);
      want("edge_handler2", S_INH, 1);
      check_all();
      bus.trap_ret = 1'b1;
      tick(1);
      bus.trap_ret = 1'b0;
      tick(1);
      want("edge_rearm_req", S_REQ, 1);
      want("edge_rearm_num", S_NUM, 2);
      check_all();
`else
      tick(1);
      want("sync1_pending", S_PEND, 0);
      want("sync1_req", S_REQ, 0);
      check_all();
      tick(1);
      want("sync2_pending", S_PEND, 16'hFF);
      want("sync2_req", S_REQ, 0);
      check_all();
      tick(1);
      want("latency_req", S_REQ, 1);
      want("latency_num", S_NUM, 0);
      check_all();
      bus.interrupt_ack = 1'b1;
      tick(1);
      bus.interrupt_ack = 1'b0;
      bus.irq_in = 8'b0010_1000;
      want("ack0_handler", S_INH, 1);
      check_all();
      tick(4);
      bus.trap_ret = 1'b1;
      tick(1);
      bus.trap_ret = 1'b0;
      want("ret_idle_req", S_REQ, 0);
      want("ret_idle_inh", S_INH, 0);
      check_all();
      tick(1);
      want("prio_req", S_REQ, 1);
      want("prio_num", S_NUM, 3);
      check_all();
      bus.irq_in = 8'b0010_1010;
      tick(4);
      want("prio_hold_req", S_REQ, 1);
      want("prio_hold_num", S_NUM, 3);
      check_all();
      bus.interrupt_ack = 1'b1;
      tick(1);
      bus.interrupt_ack = 1'b0;
      bus.irq_in = 8'h20;
      want("ack_req_drop", S_REQ, 0);
      want("ack_handler", S_INH, 1);
      check_all();
      bus.trap_valid = 1'b1;
      tick(4);
      bus.trap_valid = 1'b0;
      want("handler_no_nest", S_REQ, 0);
      want("handler_trap_stay", S_INH, 1);
      check_all();
      bus.trap_ret = 1'b1;
      tick(1);
      bus.trap_ret = 1'b0;
      want("ret1_req", S_REQ, 0);
      check_all();
      tick(1);
      want("ret2_req", S_REQ, 1);
      want("ret2_num", S_NUM, 5);
      check_all();
      bus.global_ie = 1'b0;
      tick(1);
      want("withdraw_req", S_REQ, 0);
      want("withdraw_inh", S_INH, 0);
      check_all();
      tick(3);
      want("withdraw_stays", S_REQ, 0);
      check_all();
      bus.global_ie = 1'b1;
      tick(1);
      want("rearm_req", S_REQ, 1);
      want("rearm_num", S_NUM, 5);
      check_all();
      bus.interrupt_ack = 1'b1;
      bus.global_ie = 1'b0;
      tick(1);
      bus.interrupt_ack = 1'b0;
      bus.global_ie = 1'b1;
      want("ack_beats_withdraw_inh", S_INH, 1);
      want("ack_beats_withdraw_req", S_REQ, 0);
      check_all();
      tick(2);
      bus.trap_ret = 1'b1;
      bus.irq_in = 8'h00;
      tick(1);
      bus.trap_ret = 1'b0;
      want("drop_ret_idle", S_INH, 0);
      check_all();
      tick(1);
      want("drop_req", S_REQ, 1);
      want("drop_num", S_NUM, 5);
      check_all();
      tick(1);
      want("source_withdraw", S_REQ, 0);
      check_all();
      bus.irq_in = 8'h80;
      bus.irq_enable = 8'h7F;
      tick(2);
      for (int i = 0; i < 20; i++) begin
         want("mask_no_req", S_REQ, 0);
         tick(1);
         check_all();
      end
      want("mask_pending", S_PEND, 16'h80);
      check_all();
      bus.irq_enable = 8'hFF;
      tick(1);
      want("unmask_req", S_REQ, 1);
      want("unmask_num", S_NUM, 7);
      check_all();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/riscv_i32_interrupt_sequencer.md
Name: riscv_i32_interrupt_sequencer

Overview:
- Sequences asynchronous interrupt entry for the i32 pipeline.
- Synchronises and latches up to NUM_IRQ external sources, masks them with per-source and global enables, and picks the lowest-index winner.
- Drives the pipeline interrupt request, number and target mode, and holds the request until the control-flow stage acknowledges it.
- Blocks further requests while a handler runs, until the trap return is seen.

Parameters:
- NUM_IRQ, 8, number of interrupt sources (1..16).
- TO_MODE, 3, value driven on irq_to_mode (machine mode encoding).
- SYNC_STAGES, 2, synchroniser depth on irq_in (>=2).

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- irq_in  input  NUM_IRQ  raw interrupt lines, asynchronous, active high
- irq_enable  input  NUM_IRQ  per-source enable (mie image)
- global_ie  input  1  global interrupt enable (mstatus.MIE)
- interrupt_ack  input  1  control data has taken the interrupt this cycle
- trap_valid  input  1  control-flow trap valid
- trap_ret  input  1  control-flow trap return (mret) committed
- interrupt_req  output  1  request to pipeline control
- interrupt_number  output  4  cause number of the requested interrupt
- interrupt_to_mode  output  3  target mode of the request
- irq_pending  output  NUM_IRQ  pending vector (mip image)
- in_handler  output  1  an interrupt has been taken and has not yet returned

Behaviour:
- Reset: asynchronous on reset_n low, whatever the state. All outputs and registers go to 0, interrupt_to_mode goes to TO_MODE, and the state machine goes to IDLE. Synchroniser flops are cleared.
- Sync: irq_in passes through SYNC_STAGES flops, giving irq_sync.
- Pending: irq_pending = irq_sync (level mode). Sources clear their own line.
- Candidate: cand = irq_pending & irq_enable. The winner is the lowest set index of cand. Zero-extend the index to 4 bits.
- State machine, all outputs registered:
  - IDLE → REQ when global_ie=1 and cand is non-zero. On that edge, interrupt_number latches the winner and interrupt_req becomes 1. Latency: pending visible in cycle N gives req high in N+1.
  - REQ:
    - interrupt_req=1; interrupt_number is held stable even if a lower index becomes pending.
    - If interrupt_ack=1 → HANDLER: req drops next cycle and in_handler=1.
    - Else if global_ie=0, or the latched source is no longer set in cand → IDLE (withdraw): req drops next cycle.
    - Ack and withdraw in the same cycle: ack wins.
  - HANDLER:
    - interrupt_req=0 and in_handler=1. New candidates are ignored (no nesting).
    - On trap_ret=1 → IDLE.
    - trap_valid with trap_ret=0 (synchronous trap inside the handler) has no effect on the state.
  - IDLE with trap_ret=1: ignored.
- Back-to-back: re-arbitration from IDLE happens the cycle after the return, so req can reassert at ret+2 at the earliest.
- Invariants:
  - interrupt_req and in_handler are never both 1.
  - interrupt_number changes only on the IDLE→REQ edge.

Optional Feature:
- Macro: RISCV_I32_INTERRUPT_SEQUENCER_EDGE_EN.
- Defined: each source is rising-edge detected on irq_sync and sets a sticky pending bit. The pending bit for the winner clears on the cycle interrupt_ack is seen in REQ. An edge and a clear of the same bit in the same cycle leaves the bit set. Withdraw applies only on global_ie or irq_enable dropping.
- Undefined: level behaviour as described above; no edge registers.

Decomposition:
- Package riscv_i32_interrupt_pkg holds:
  - the state enum (IDLE, REQ, HANDLER);
  - the mode encoding constants (machine=3);
  - the width constant for interrupt_number.
- One natural sub-module, riscv_i32_irq_priority_encoder: combinational find-first-set over NUM_IRQ bits, producing the index and an any-flag.

Test Plan:
- Reset: hold reset_n=0 with irq_in=8'hFF → req=0, pending=0, in_handler=0, to_mode=3. Release, with enables 8'hFF and global_ie=1 → req=1 with number=0 at SYNC_STAGES+1 cycles after release.
- Priority: irq_in=8'b0010_1000, enable=8'hFF → number=3. Raise irq_in[1] while in REQ → number stays 3 until ack.
- Handshake: from REQ, pulse interrupt_ack → req=0 and in_handler=1 next cycle. Irq 5 pending in HANDLER → no req. Pulse trap_ret → req=1 with number=5 two cycles later.
- Withdraw: in REQ, drop global_ie → req=0 next cycle, state IDLE. Repeat with ack and global_ie dropping in the same cycle → HANDLER entered.
- Masking: irq_in=8'h80 with enable=8'h7F → req never asserts over 20 cycles while irq_pending=8'h80. Set enable[7] → req with number=7.
- Edge (macro on): a 1-cycle pulse on irq_in[2] → pending[2] stays set until ack, then clears. A second pulse landing on the ack cycle keeps pending[2]=1.
